memory_bus_arbiter: RTL and testbench
=====================================

# memory_bus_arbiter

Shares the single DRAM memory bus between the core's memory requesters: fetch on port 0, load/store on port 1 and a spare port on port 2. Only one transaction is outstanding at a time. It is granted round-robin, issued to the DRAM, and completed with a one-cycle response pulse to the owning requester. A watchdog converts a missing DRAM response into an error response so the pipeline cannot hang on the bus.

## Interface
Parameters:
- NUM_REQ, 3, number of requester ports (2..8)
- ADDR_W, 21, physical memory address width
- DATA_W, 64, data word width
- TIMEOUT_CYCLES, 255, max WAIT cycles before error response (≥1)

Ports:
- clk  in  1  clock; all logic on posedge
- reset_n  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  requester i has a request pending
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  per-requester address, port i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  per-requester write data
- req_ready  out  NUM_REQ  one-hot accept pulse; request is latched this cycle
- rsp_valid  out  NUM_REQ  one-hot completion pulse to the owner
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid
- rsp_error  out  1  timeout flag, valid with rsp_valid
- mem_req_valid  out  1  request to DRAM
- mem_req_write  out  1  DRAM write enable
- mem_req_addr  out  ADDR_W  DRAM address
- mem_req_wdata  out  DATA_W  DRAM write data
- mem_req_ready  in  1  DRAM accepts the request
- mem_rsp_valid  in  1  DRAM completion, for reads and writes
- mem_rsp_rdata  in  DATA_W  DRAM read data
- busy  out  1  state ≠ IDLE

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP.
- **IDLE:** if any req_valid is set, select a winner and assert req_ready[winner] combinationally in this cycle. On the clock edge, latch owner, write, addr and wdata, then go to ISSUE. If no request is pending, stay in IDLE.
- **Round-robin:** search starts at last_grant+1 modulo NUM_REQ; the first set req_valid wins.
- **ISSUE:** drive mem_req_* from the latched fields.
  - On mem_req_ready=1, clear the timer and go to WAIT.
  - Otherwise hold all fields stable and stay in ISSUE. There is no timeout in ISSUE.
- **WAIT:** the timer increments each cycle.
  - If mem_rsp_valid=1, capture mem_rsp_rdata, set error=0 and go to RESP.
  - Else, if the timer reaches TIMEOUT_CYCLES, set rdata=0 and error=1, then go to RESP.
  - If both happen in the same cycle, the response wins (error=0).
- **RESP:** assert rsp_valid[owner] for exactly one cycle, with rsp_rdata and rsp_error. Set last_grant=owner and return to IDLE.
- A new grant is possible in the cycle after RESP.
- mem_rsp_valid is ignored outside WAIT.
- The DRAM is required not to respond after a timeout. A late response that arrives during a later WAIT is misattributed; this is a documented limitation.
- Writes also wait for mem_rsp_valid. For writes, rsp_rdata is 0.
- Requester duties:
  - Drop or change req_valid after seeing req_ready.
  - Do not issue a new request before its rsp_valid.
- Width rules:
  - The timer is $clog2(TIMEOUT_CYCLES+1) bits and saturates.
  - last_grant is $clog2(NUM_REQ) bits.
  - Wrap-around: from NUM_REQ-1 the search moves to 0.

## Timing
- Reset (reset_n=0 at a posedge), values after the edge:
  - state=IDLE, timer=0, busy=0
  - All rsp_valid, mem_req_valid, mem_req_write, rsp_error and rsp_rdata are 0; mem_req_addr and mem_req_wdata are 0.
  - last_grant=NUM_REQ-1, so port 0 is favoured first.
  - req_ready=0 while reset_n=0.
- Reset mid-transaction aborts it. No rsp_valid is produced and the latched request is discarded.
- Minimum latency:
  - Cycle 0: req_ready.
  - Cycle 1: mem_req_valid; mem_req_ready=1 in this cycle.
  - Cycle 2: WAIT; mem_rsp_valid=1 in this cycle.
  - Cycle 3: rsp_valid.
- Throughput is at most one transaction per 4 cycles.
- Timeout: rsp_valid with rsp_error=1 occurs TIMEOUT_CYCLES+1 cycles after entering WAIT.

## Configuration
- ARBITER_FETCH_PRIORITY_EN:
  - **Defined:** port 0 (fetch) wins whenever req_valid[0]=1, regardless of last_grant. Other ports are round-robin among themselves when port 0 is idle.
  - **Undefined:** pure round-robin over all ports, as described in Operation.

## Test plan
- **Reset:** hold reset_n=0 for 3 cycles with all req_valid=1 → req_ready=0, mem_req_valid=0, busy=0. After release, the first grant goes to port 0.
- **Round-robin:** all ports request reads continuously; DRAM answers in 1 cycle → grants go 0,1,2,0,1,2. Each rsp_valid is one-hot and matches the grant, 4 cycles apart.
- **Read data path:** port 1 reads addr 0x1F_FFF0; DRAM returns 0xDEAD_BEEF_0123_4567 → rsp_valid[1] with that data and rsp_error=0, 3 cycles after req_ready.
- **Backpressure:** mem_req_ready=0 for 5 cycles → mem_req_* stable and no timeout. Completion is 5 cycles later than nominal.
- **Timeout:** TIMEOUT_CYCLES=4; DRAM never responds → rsp_valid[owner] with rsp_error=1 and rsp_rdata=0, 5 cycles after entering WAIT. The next request is then served normally.
- **Priority macro:** with ARBITER_FETCH_PRIORITY_EN defined and ports 0 and 2 requesting continuously → port 0 is always granted. Undefined → grants alternate 0,2.

Source files
------------

// File: rtl/memory_bus_arbiter.sv
// rtl/memory_bus_arbiter.sv - round-robin DRAM bus arbiter with response watchdog
// Optional build macro: ARBITER_FETCH_PRIORITY_EN (port 0 always wins when requesting)
module memory_bus_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_W         = 21,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_error,
    output logic                      mem_req_valid,
    output logic                      mem_req_write,
    output logic [ADDR_W-1:0]         mem_req_addr,
    output logic [DATA_W-1:0]         mem_req_wdata,
    input  logic                      mem_req_ready,
    input  logic                      mem_rsp_valid,
    input  logic [DATA_W-1:0]         mem_rsp_rdata,
    output logic                      busy
);
    localparam int LG_W  = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [LG_W-1:0]  LAST_RST = LG_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [LG_W-1:0]   owner_q, owner_d;
    logic [LG_W-1:0]   last_q, last_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              error_q, error_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic [NUM_REQ-1:0] cand;
    logic [LG_W-1:0]    ptr;
    logic [LG_W-1:0]    winner;
    logic               found;

    // Walk the ports starting one past the last owner, wrapping at NUM_REQ-1.
    always_comb begin
        cand = req_valid;
`ifdef ARBITER_FETCH_PRIORITY_EN
        cand[0] = 1'b0;
`endif
        ptr    = last_q;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ptr = (ptr == LAST_RST) ? '0 : ptr + LG_W'(1);
            if (!found && cand[ptr]) begin
                found  = 1'b1;
                winner = ptr;
            end
        end
`ifdef ARBITER_FETCH_PRIORITY_EN
        if (req_valid[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    owner_d = winner;
                    write_d = req_write[winner];
                    addr_d  = req_addr[winner*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata[winner*DATA_W +: DATA_W];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
                // A response arriving on the timeout cycle still counts as success.
                if (mem_rsp_valid) begin
                    rdata_d = write_q ? '0 : mem_rsp_rdata;
                    error_d = 1'b0;
                    state_d = ST_RESP;
                end else if (timer_q == TMR_MAX) begin
                    rdata_d = '0;
                    error_d = 1'b1;
                    state_d = ST_RESP;
                end
            end
            default: begin
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= LAST_RST;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            timer_q <= timer_d;
        end
    end

    assign req_ready     = (reset_n && state_q == ST_IDLE && found) ? (NUM_REQ'(1) << winner) : '0;
    assign rsp_valid     = (state_q == ST_RESP) ? (NUM_REQ'(1) << owner_q) : '0;
    assign rsp_rdata     = (state_q == ST_RESP) ? rdata_q : '0;
    assign rsp_error     = (state_q == ST_RESP) && error_q;
    assign mem_req_valid = (state_q == ST_ISSUE);
    assign mem_req_write = (state_q == ST_ISSUE) && write_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign busy          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb/tb_memory_bus_arbiter.sv - table-driven bench for memory_bus_arbiter (TIMEOUT_CYCLES=4)
module tb_memory_bus_arbiter;
    localparam int N  = 3;
    localparam int AW = 21;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, mem_req_wdata, mem_rsp_rdata;
    logic            rsp_error, mem_req_valid, mem_req_write, mem_req_ready, mem_rsp_valid, busy;
    logic [AW-1:0]   mem_req_addr;

    memory_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    rv;
        logic [2:0]    rw;
        logic          mrdy;
        logic          mrsp;
        logic [63:0]   md;
        logic [2:0]    e_rdy;
        logic [2:0]    e_rsp;
        logic          e_mval;
        logic          e_mwr;
        logic [AW-1:0] e_addr;
        logic [63:0]   e_wdata;
        logic [63:0]   e_rdata;
        logic          e_err;
        logic          e_busy;
    } vec_t;

    localparam logic [63:0] JUNK = 64'hFFFF_0000_FFFF_0000;

    vec_t          tbl[24];
    logic [AW-1:0] A[3];
    logic [DW-1:0] W[3];
    logic [2:0]    pexp[4];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            p;
    logic [2:0]    oh, wm;
    logic          wr;
    logic [63:0]   dk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic [2:0] rv, input logic mrdy, input logic mrsp, input logic [63:0] md);
        req_valid     = rv;
        req_write     = 3'b000;
        mem_req_ready = mrdy;
        mem_rsp_valid = mrsp;
        mem_rsp_rdata = md;
        #1;
    endtask

    task automatic adv;
        @(negedge clk);
    endtask

    initial begin
        A[0] = 21'h000100; A[1] = 21'h1FFFF0; A[2] = 21'h0ABCDE;
        W[0] = 64'hAAAA_5555_0000_0000; W[1] = 64'hAAAA_5555_0000_0001; W[2] = 64'hAAAA_5555_0000_0002;
        req_addr  = {A[2], A[1], A[0]};
        req_wdata = {W[2], W[1], W[0]};

        // Six back-to-back transactions, grant order 0,1,2,0,1,2; the fifth is a write.
        for (int k = 0; k < 6; k++) begin
            p  = k % 3;
            oh = 3'b001 << p;
            wr = (k == 4);
            wm = wr ? oh : 3'b000;
            dk = (k == 1) ? 64'hDEAD_BEEF_0123_4567 : 64'h1000_0000_0000_0000 + 64'(k);
            tbl[k*4+0] = '{3'b111, wm, 1'b1, 1'b1, JUNK, oh, 3'b000, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0};
            tbl[k*4+1] = '{3'b111, wm, 1'b1, 1'b1, JUNK, 3'b000, 3'b000, 1'b1, wr, A[p], W[p], '0, 1'b0, 1'b1};
            tbl[k*4+2] = '{3'b111, wm, 1'b1, 1'b1, dk, 3'b000, 3'b000, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1};
            tbl[k*4+3] = '{3'b111, wm, 1'b1, 1'b1, JUNK, 3'b000, oh, 1'b0, 1'b0, '0, '0,
                           wr ? 64'h0 : dk, 1'b0, 1'b1};
        end

        reset_n = 1'b0;
        step(3'b111, 1'b1, 1'b1, JUNK);
        adv;
        for (int i = 0; i < 3; i++) begin
            step(3'b111, 1'b1, 1'b1, JUNK);
            chk("rst_ready", req_ready, 0);
            chk("rst_mval", mem_req_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rsp", rsp_valid, 0);
            chk("rst_mwr", mem_req_write, 0);
            chk("rst_addr", mem_req_addr, 0);
            chk("rst_wdata", mem_req_wdata, 0);
            chk("rst_rdata", rsp_rdata, 0);
            chk("rst_err", rsp_error, 0);
            adv;
        end
        reset_n = 1'b1;

        for (int r = 0; r < 24; r++) begin
            req_valid     = tbl[r].rv;
            req_write     = tbl[r].rw;
            mem_req_ready = tbl[r].mrdy;
            mem_rsp_valid = tbl[r].mrsp;
            mem_rsp_rdata = tbl[r].md;
            #1;
            chk($sformatf("rr%0d_ready", r), req_ready, tbl[r].e_rdy);
            chk($sformatf("rr%0d_rsp", r), rsp_valid, tbl[r].e_rsp);
            chk($sformatf("rr%0d_mval", r), mem_req_valid, tbl[r].e_mval);
            chk($sformatf("rr%0d_busy", r), busy, tbl[r].e_busy);
            if (tbl[r].e_mval) begin
                chk($sformatf("rr%0d_addr", r), mem_req_addr, tbl[r].e_addr);
                chk($sformatf("rr%0d_wdata", r), mem_req_wdata, tbl[r].e_wdata);
                chk($sformatf("rr%0d_mwr", r), mem_req_write, tbl[r].e_mwr);
            end
            if (tbl[r].e_rsp != 3'b000) begin
                chk($sformatf("rr%0d_rdata", r), rsp_rdata, tbl[r].e_rdata);
                chk($sformatf("rr%0d_err", r), rsp_error, tbl[r].e_err);
            end
            adv;
        end

        // Backpressure: five stalled ISSUE cycles, fields must not follow the changed input.
        step(3'b001, 1'b0, 1'b0, 64'h0);
        chk("bp_ready", req_ready, 3'b001);
        adv;
        req_addr[0 +: AW] = 21'h012345;
        for (int i = 0; i < 5; i++) begin
            step(3'b000, 1'b0, 1'b1, JUNK);
            chk("bp_mval", mem_req_valid, 1);
            chk("bp_addr", mem_req_addr, A[0]);
            chk("bp_rsp", rsp_valid, 0);
            adv;
        end
        step(3'b000, 1'b1, 1'b0, 64'h0);
        chk("bp_mval_last", mem_req_valid, 1);
        adv;
        step(3'b000, 1'b0, 1'b1, 64'h5555_6666_7777_8888);
        chk("bp_wait_rsp", rsp_valid, 0);
        chk("bp_wait_mval", mem_req_valid, 0);
        adv;
        step(3'b000, 1'b0, 1'b0, 64'h0);
        chk("bp_rsp_valid", rsp_valid, 3'b001);
        chk("bp_rdata", rsp_rdata, 64'h5555_6666_7777_8888);
        chk("bp_err", rsp_error, 0);
        adv;
        req_addr[0 +: AW] = A[0];

        // Timeout: DRAM never answers, error response 5 cycles after entering WAIT.
        step(3'b100, 1'b1, 1'b0, 64'h0);
        chk("to_ready", req_ready, 3'b100);
        adv;
        step(3'b000, 1'b1, 1'b0, 64'h0);
        chk("to_mval", mem_req_valid, 1);
        adv;
        for (int i = 0; i < 5; i++) begin
            step(3'b000, 1'b0, 1'b0, 64'hBAD0_BAD0_BAD0_BAD0);
            chk("to_wait_rsp", rsp_valid, 0);
            chk("to_wait_busy", busy, 1);
            adv;
        end
        step(3'b000, 1'b0, 1'b0, 64'hBAD0_BAD0_BAD0_BAD0);
        chk("to_rsp_valid", rsp_valid, 3'b100);
        chk("to_err", rsp_error, 1);
        chk("to_rdata", rsp_rdata, 0);
        adv;

        // Normal read after a timeout.
        step(3'b010, 1'b1, 1'b0, 64'h0);
        chk("post_ready", req_ready, 3'b010);
        adv;
        step(3'b000, 1'b1, 1'b0, 64'h0);
        adv;
        step(3'b000, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF);
        adv;
        step(3'b000, 1'b0, 1'b0, 64'h0);
        chk("post_rsp", rsp_valid, 3'b010);
        chk("post_err", rsp_error, 0);
        chk("post_rdata", rsp_rdata, 64'h0123_4567_89AB_CDEF);
        adv;

        // Response on the timeout cycle beats the watchdog.
        step(3'b001, 1'b1, 1'b0, 64'h0);
        chk("tie_ready", req_ready, 3'b001);
        adv;
        step(3'b000, 1'b1, 1'b0, 64'h0);
        adv;
        for (int i = 0; i < 4; i++) begin
            step(3'b000, 1'b0, 1'b0, 64'h0);
            chk("tie_wait_rsp", rsp_valid, 0);
            adv;
        end
        step(3'b000, 1'b0, 1'b1, 64'h7777_0000_7777_0000);
        adv;
        step(3'b000, 1'b0, 1'b0, 64'h0);
        chk("tie_rsp", rsp_valid, 3'b001);
        chk("tie_err", rsp_error, 0);
        chk("tie_rdata", rsp_rdata, 64'h7777_0000_7777_0000);
        adv;

        // Ports 0 and 2 requesting continuously, last owner was port 0.
`ifdef ARBITER_FETCH_PRIORITY_EN
        pexp[0] = 3'b001; pexp[1] = 3'b001; pexp[2] = 3'b001; pexp[3] = 3'b001;
`else
        pexp[0] = 3'b100; pexp[1] = 3'b001; pexp[2] = 3'b100; pexp[3] = 3'b001;
`endif
        for (int g = 0; g < 4; g++) begin
            step(3'b101, 1'b1, 1'b1, 64'(g));
            chk($sformatf("prio%0d_ready", g), req_ready, pexp[g]);
            adv;
            step(3'b101, 1'b1, 1'b1, 64'(g));
            adv;
            step(3'b101, 1'b1, 1'b1, 64'(g));
            adv;
            step(3'b101, 1'b1, 1'b1, 64'(g));
            chk($sformatf("prio%0d_rsp", g), rsp_valid, pexp[g]);
            adv;
        end

        // Reset during ISSUE aborts without a response; arbitration restarts at port 0.
        step(3'b010, 1'b0, 1'b0, 64'h0);
        chk("abort_ready", req_ready, 3'b010);
        adv;
        step(3'b000, 1'b0, 1'b0, 64'h0);
        chk("abort_issue", mem_req_valid, 1);
        adv;
        reset_n = 1'b0;
        step(3'b111, 1'b1, 1'b1, 64'h0);
        chk("abort_rst_ready", req_ready, 0);
        adv;
        reset_n = 1'b1;
        step(3'b000, 1'b1, 1'b1, 64'h0);
        chk("abort_busy", busy, 0);
        chk("abort_rsp", rsp_valid, 0);
        chk("abort_mval", mem_req_valid, 0);
        step(3'b111, 1'b1, 1'b1, 64'h0);
        chk("abort_first_grant", req_ready, 3'b001);
        adv;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
